// File: rtl/arb_req_queue.sv
// Request-side front end for a matrix arbiter: one FIFO per requester drives req,
// and a legal grant pops the granted head into a single tagged valid/ready output.
module arb_req_queue #(
  parameter int unsigned N     = 3,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IDW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     req,
  input  logic [N-1:0]     gnt,
  input  logic             valid_gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDW-1:0]   out_id,
  output logic             gnt_err,
  output logic             gnt_drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q    [N][DEPTH];
  logic [PW-1:0] wr_ptr_q [N];
  logic [PW-1:0] rd_ptr_q [N];
  logic [CW-1:0] cnt_q    [N];

  logic [N-1:0]   push;
  logic [N-1:0]   pop_vec;
  logic           gnt_onehot;
  logic           legal;
  logic           illegal;
  logic           out_free;
  logic           pop;
  logic [IDW-1:0] gnt_idx;
  logic [W-1:0]   head;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i]      = (cnt_q[i] != '0);
      in_ready[i] = (cnt_q[i] != CW'(DEPTH));
    end
  end

  // Grant decode; gnt_idx/head only meaningful when gnt is one-hot.
  always_comb begin
    gnt_idx = '0;
    head    = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gnt_idx = IDW'(i);
        head    = mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  assign gnt_onehot = (gnt != '0) && ((gnt & (gnt - 1'b1)) == '0);
  assign legal      = valid_gnt && gnt_onehot && ((gnt & req) != '0);
  assign illegal    = valid_gnt && !legal;
  assign out_free   = !out_valid || out_ready;
  assign pop        = legal && out_free;
  assign pop_vec    = pop ? gnt : '0;
  assign push       = in_valid & in_ready;

  // Payload storage needs no reset: occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i])    wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop_vec[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop_vec[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      gnt_err   <= 1'b0;
      gnt_drop  <= 1'b0;
    end else begin
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= head;
        out_id    <= gnt_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      gnt_drop <= legal && !out_free;
      if (illegal) gnt_err <= 1'b1;
    end
  end

endmodule

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
- Request-side front end for the priority_matrix arbiter.
- Holds one small FIFO per requester and drives the arbiter's req vector from FIFO occupancy.
- Consumes gnt/valid_gnt to pop the granted requester's head entry.
- Presents that entry on a single valid/ready output port tagged with the requester index.

Parameters:
N, 3, number of requesters (matches arbiter N)
W, 8, payload width per request
DEPTH, 4, entries per requester FIFO; power of 2, >= 2

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  N  per-requester push strobe
in_ready  output  N  per-requester FIFO not full
in_data  input  N*W  payload; requester i occupies bits [i*W +: W]
req  output  N  to arbiter: req[i] = FIFO i non-empty
gnt  input  N  from arbiter: one-hot grant vector
valid_gnt  input  1  from arbiter: gnt is valid this cycle
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts output entry
out_data  output  W  granted payload
out_id  output  $clog2(N) (min 1)  index of requester that supplied out_data
gnt_err  output  1  sticky error flag, cleared only by rst
gnt_drop  output  1  one-cycle pulse when a legal grant is discarded due to output stall

Behaviour:
- One clock domain: clk, with asynchronous active-high rst.
- Reset values:
  - all FIFOs empty (pointers and counts 0), so req=0 and in_ready all 1
  - out_valid=0, out_data=0, out_id=0, gnt_err=0, gnt_drop=0
- rst asserted mid-operation: all stored entries and any held output are discarded immediately. No pop or push completes in that cycle.
- Push: entry i is written when in_valid[i] && in_ready[i] at the clk edge.
  - in_ready[i] = !full[i], registered-state derived with no combinational path from pop.
  - A full FIFO does not accept a push in the same cycle it is popped. The entry is accepted next cycle.
- req[i] = (count[i] != 0), derived from registers only. A push raises req[i] the cycle after acceptance.
- out_free = !out_valid || out_ready.
- Legal grant: valid_gnt=1 && gnt is exactly one-hot && req[gnt index]=1.
- Legal grant with out_free=1:
  - pop the head of FIFO k (k = gnt index)
  - load out_data <= head[k], out_id <= k, out_valid <= 1 at the same edge
  - latency is 1 cycle from the grant cycle to out_valid
- Legal grant with out_free=0: no pop, output unchanged, gnt_drop=1 for one cycle. The requester keeps req high and re-arbitrates.
- Illegal grant, with no pop and nothing else changed:
  - gnt zero, multi-hot, or pointing at an empty FIFO, while valid_gnt=1
  - gnt_err is set to 1 and holds until rst
- valid_gnt=0: gnt is ignored entirely.
- Output handshake:
  - out_valid=1 && out_ready=1 with no new pop → out_valid <= 0
  - out_valid=1 && out_ready=1 with a pop in the same cycle → new entry replaces the old one (back-to-back, full throughput)
  - out_valid=1 && out_ready=0 → out_data and out_id held stable
- Simultaneous push and pop on the same FIFO:
  - allowed when not full; count unchanged
  - on an empty FIFO a pop cannot occur (req=0), so the push lands and req rises next cycle
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Ordering: per-requester FIFO order is preserved. Cross-requester order is decided solely by the arbiter.

Test Plan:
- Reset: assert rst mid-cycle with entries queued → req=000, in_ready=111, out_valid=0 immediately (async); after release, push to FIFO 1 works normally.
- Single path: push 0xA5 to requester 1 → req=010 next cycle; drive valid_gnt=1, gnt=010 → next cycle out_valid=1, out_data=0xA5, out_id=1, req=000.
- Full/wrap: push 4 entries (0x10..0x13) to requester 2 → in_ready[2]=0; 5th push stalls; grant twice, push 0x14 and 0x15 → outputs 0x10, 0x11; then 4 more grants yield 0x12, 0x13, 0x14, 0x15 in order (pointer wrap).
- Stall: out_valid=1, out_ready=0, legal grant gnt=001 → gnt_drop pulses 1 cycle, FIFO 0 count unchanged, out_data held; raise out_ready with the same grant → back-to-back pop, out_id=0.
- Illegal grants: valid_gnt=1 with gnt=011, then gnt=100 with FIFO 2 empty → no pops, gnt_err=1 and stays 1 until rst.
- Full arbitration: feed req into priority_matrix (N=3, rows 110/000/010) with all three FIFOs holding 2 entries; drain with out_ready=1 → out_id sequence matches arbiter grants, 6 entries out, each FIFO in order, req ends 000.
